// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: picks a random lane each round, arms the hit
// checker, collects its verdict or a timeout, and keeps score and lives. The
// round timeout shrinks as the score climbs, and the game ends when lives run out.
module mole_round_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned TIMEOUT_MIN    = 12500000,
  parameter int unsigned TIMEOUT_STEP   = 5000000,
  parameter int unsigned GAP_CYCLES     = 25000000,
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_game,
  input  logic [3:0]         buttons,
  input  logic [1:0]         give_lose_point,
  output logic [1:0]         random_num,
  output logic               start_checks,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               game_over,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ARM,
    S_WAIT,
    S_RESOLVE,
    S_OVER
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0]        cnt;
  logic [31:0]        timeout_cur;
  logic [7:0]         lfsr;
  logic               lfsr_fb;
  logic               res_hit;
  logic               verdict_hit;
  logic               verdict_miss;
  logic               buttons_idle;
  logic               wait_expired;
  logic [SCORE_W-1:0] score_inc;
  logic [3:0]         lives_dec;
  logic [31:0]        timeout_next;

  // Shared helper terms for the FSM and the datapath
  always_comb begin
    lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    verdict_hit  = (give_lose_point == 2'b11);
    verdict_miss = (give_lose_point == 2'b01);
    buttons_idle = (buttons == 4'hF);
    wait_expired = (cnt == timeout_cur - 32'd1);
    score_inc    = (score == '1) ? score : score + 1'b1;
    lives_dec    = lives - 4'd1;
    if (timeout_cur < TIMEOUT_MIN + TIMEOUT_STEP)
      timeout_next = TIMEOUT_MIN;
    else
      timeout_next = timeout_cur - TIMEOUT_STEP;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_OVER: if (start_game) next_state = S_GAP;
      S_GAP:          if (buttons_idle && cnt == GAP_CYCLES - 1) next_state = S_ARM;
      S_ARM:          next_state = S_WAIT;
      S_WAIT:         if (verdict_hit || verdict_miss || wait_expired) next_state = S_RESOLVE;
      // Decide OVER from the life count before it is decremented in this cycle
      S_RESOLVE:      next_state = (!res_hit && lives == 4'd1) ? S_OVER : S_GAP;
      default:        next_state = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    game_over = (state == S_OVER);
  end

  // Datapath: LFSR, round counter, score/lives/timeout and checker handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr         <= 8'hA5;
      cnt          <= '0;
      timeout_cur  <= TIMEOUT_CYCLES;
      res_hit      <= 1'b0;
      random_num   <= '0;
      start_checks <= 1'b0;
      score        <= '0;
      lives        <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr_fb};
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      // One counter serves both GAP and WAIT; it restarts on every state change
      if (state != next_state)
        cnt <= '0;
      else if (state == S_GAP && !buttons_idle)
        cnt <= '0;
      else if (state == S_GAP || state == S_WAIT)
        cnt <= cnt + 32'd1;
      else
        cnt <= '0;

      unique case (state)
        S_IDLE, S_OVER: begin
          if (start_game) begin
            score       <= '0;
            lives       <= 4'(START_LIVES);
            timeout_cur <= TIMEOUT_CYCLES;
          end
        end
        S_GAP: start_checks <= 1'b0;
        S_ARM: begin
          random_num   <= lfsr[1:0];
          start_checks <= 1'b1;
        end
        // A hit verdict on the timeout cycle still counts as a hit
        S_WAIT: res_hit <= verdict_hit;
        S_RESOLVE: begin
          start_checks <= 1'b0;
          if (res_hit) begin
            score     <= score_inc;
            hit_pulse <= 1'b1;
            if (score_inc[2:0] == 3'd0) timeout_cur <= timeout_next;
          end else begin
            lives      <= lives_dec;
            miss_pulse <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl with shortened timing parameters.
module tb_mole_round_ctrl;

  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_game = 1'b0;
  logic [3:0]    buttons = 4'hF;
  logic [1:0]    gl = 2'b00;
  logic [1:0]    random_num;
  logic          start_checks;
  logic [SW-1:0] score;
  logic [3:0]    lives;
  logic          game_over;
  logic          hit_pulse;
  logic          miss_pulse;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr;

  mole_round_ctrl #(
    .TIMEOUT_CYCLES(20),
    .TIMEOUT_MIN   (8),
    .TIMEOUT_STEP  (4),
    .GAP_CYCLES    (4),
    .START_LIVES   (3),
    .SCORE_W       (SW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_game     (start_game),
    .buttons        (buttons),
    .give_lose_point(gl),
    .random_num     (random_num),
    .start_checks   (start_checks),
    .score          (score),
    .lives          (lives),
    .game_over      (game_over),
    .hit_pulse      (hit_pulse),
    .miss_pulse     (miss_pulse)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 8,6,5,4, seeded by reset
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits until start_checks is high; n = edges waited. Checks the lane drawn in ARM.
  task automatic wait_arm(output int n);
    logic [7:0] prev;
    n = 0;
    prev = m_lfsr;
    while (start_checks !== 1'b1 && n < 60) begin
      prev = m_lfsr;
      tick;
      n++;
    end
    check("arm_reached", 32'(n < 60), 32'd1);
    check("random_num", 32'(random_num), 32'(prev[1:0]));
  endtask

  // From WAIT cycle 1: drive verdict v during WAIT cycle vcyc (0 = never),
  // return edges until a hit/miss pulse is seen.
  task automatic run_wait(input int vcyc, input logic [1:0] v, output int n);
    n = 0;
    while (!(hit_pulse === 1'b1 || miss_pulse === 1'b1) && n < 100) begin
      gl = (n + 1 == vcyc) ? v : 2'b00;
      tick;
      n++;
    end
    gl = 2'b00;
  endtask

  task automatic hit_round;
    int n;
    wait_arm(n);
    run_wait(1, 2'b11, n);
    check("hit_latency", 32'(n), 32'd2);
    check("hit_round_pulse", 32'(hit_pulse), 32'd1);
  endtask

  task automatic timeout_round(input int exp_n, input logic [3:0] exp_lives);
    int n;
    wait_arm(n);
    run_wait(0, 2'b00, n);
    check("timeout_len", 32'(n), 32'(exp_n));
    check("timeout_miss", 32'(miss_pulse), 32'd1);
    check("timeout_lives", 32'(lives), 32'(exp_lives));
  endtask

  task automatic new_game;
    start_game = 1'b1;
    tick;
    start_game = 1'b0;
    check("start_lives", 32'(lives), 32'd3);
    check("start_score", 32'(score), 32'd0);
    check("start_game_over", 32'(game_over), 32'd0);
  endtask

  initial begin
    int n;
    int bad;

    // Reset values
    tick;
    tick;
    check("rst_start_checks", 32'(start_checks), 32'd0);
    check("rst_random_num", 32'(random_num), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
    rst = 1'b0;
    tick;

    // Game 1: start and arm latency (6 edges including the sampling edge)
    new_game;
    wait_arm(n);
    check("arm_latency", 32'(n + 1), 32'd6);

    // Hit on 2nd WAIT cycle
    run_wait(2, 2'b11, n);
    check("hit_n", 32'(n), 32'd3);
    check("hit_pulse", 32'(hit_pulse), 32'd1);
    check("hit_no_miss", 32'(miss_pulse), 32'd0);
    check("hit_score", 32'(score), 32'd1);
    check("hit_lives", 32'(lives), 32'd3);
    check("hit_checks_low", 32'(start_checks), 32'd0);
    tick;
    check("hit_pulse_1cyc", 32'(hit_pulse), 32'd0);

    // Wrong button while start_game is held high (must be ignored)
    start_game = 1'b1;
    wait_arm(n);
    run_wait(1, 2'b01, n);
    start_game = 1'b0;
    check("wrong_n", 32'(n), 32'd2);
    check("wrong_miss", 32'(miss_pulse), 32'd1);
    check("wrong_lives", 32'(lives), 32'd2);
    check("wrong_score", 32'(score), 32'd1);

    // A pressed button stalls the gap
    buttons = 4'hE;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (start_checks !== 1'b0) bad++;
    end
    check("gap_held", 32'(bad), 32'd0);
    buttons = 4'hF;
    wait_arm(n);
    check("gap_release_latency", 32'(n), 32'd5);

    // Hit on the timeout cycle wins
    run_wait(20, 2'b11, n);
    check("late_hit_n", 32'(n), 32'd21);
    check("late_hit_pulse", 32'(hit_pulse), 32'd1);
    check("late_hit_score", 32'(score), 32'd2);
    check("late_hit_lives", 32'(lives), 32'd2);

    // 2'b10 is ignored, round times out after 20 WAIT cycles
    wait_arm(n);
    run_wait(2, 2'b10, n);
    check("ign10_n", 32'(n), 32'd21);
    check("ign10_miss", 32'(miss_pulse), 32'd1);
    check("ign10_lives", 32'(lives), 32'd1);

    // Last life lost -> OVER
    timeout_round(21, 4'd0);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_checks", 32'(start_checks), 32'd0);
    check("over_score", 32'(score), 32'd2);
    for (int i = 0; i < 6; i++) tick;
    check("over_hold_flag", 32'(game_over), 32'd1);
    check("over_hold_score", 32'(score), 32'd2);
    check("over_hold_lives", 32'(lives), 32'd0);
    check("over_hold_checks", 32'(start_checks), 32'd0);

    // Game 2: timeout shrinks 20 -> 16 (score 8) -> 8 (score 24), floor at 8 (score 32)
    new_game;
    for (int i = 0; i < 8; i++) hit_round;
    check("score8", 32'(score), 32'd8);
    timeout_round(17, 4'd2);
    for (int i = 0; i < 16; i++) hit_round;
    check("score24", 32'(score), 32'd24);
    timeout_round(9, 4'd1);
    for (int i = 0; i < 8; i++) hit_round;
    check("score32", 32'(score), 32'd32);
    timeout_round(9, 4'd0);
    check("g2_over", 32'(game_over), 32'd1);

    // Game 3: score saturation
    new_game;
    for (int i = 0; i < 255; i++) hit_round;
    check("score255", 32'(score), 32'd255);
    hit_round;
    check("score_sat", 32'(score), 32'd255);
    check("sat_lives", 32'(lives), 32'd3);

    // Reset in the middle of WAIT
    wait_arm(n);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_checks", 32'(start_checks), 32'd0);
    check("midrst_lives", 32'(lives), 32'd0);
    check("midrst_score", 32'(score), 32'd0);
    check("midrst_random", 32'(random_num), 32'd0);
    check("midrst_game_over", 32'(game_over), 32'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (start_checks !== 1'b0) bad++;
    end
    check("midrst_idle", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
